randomizer_par: RTL and testbench
=================================

# randomizer_par

Parametrised, word-wide successor to the serial WiMAX OFDM randomizer. Scrambles W data bits per clock with the 802.16 PRBS 1 + x^14 + x^15, seeded per burst from a 15-bit IV, with valid/ready handshakes on both sides, a burst-length counter that closes each burst, and a bypass mode. Sits between the MAC-side bit source and the FEC encoder.

## Interface
- W, 8, data bits per beat (1..64); word bit 0 is the earliest bit in time.
- LEN_W, 16, width of the burst length counter (beats).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rand_iv  in  15  seed; rand_iv[0] = LFSR stage 1, rand_iv[14] = stage 15.
- reload  in  1  load rand_iv, burst_len and bypass; start a burst.
- burst_len  in  LEN_W  beats in the burst, sampled on reload.
- bypass  in  1  sampled on reload; 1 = pass data unscrambled (LFSR still advances).
- in_bits  in  W  input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word this cycle.
- out_bits  out  W  scrambled word.
- out_valid  out  1  out_bits valid.
- out_ready  in  1  downstream accepts out_bits.
- out_last  out  1  qualifies out_bits as the burst's final beat.
- busy  out  1  state is RUN.

## Operation
- LFSR s[14:0]. One bit step: fb = s[13] ^ s[14]; out = in ^ fb (in if bypass); s <= {s[13:0], fb}. A beat applies W steps in order, bit 0 first, in one cycle (unrolled).
- States: IDLE, RUN.
  - IDLE: in_ready = 0. reload -> RUN; s <= rand_iv, count <= burst_len, mode <= bypass. If burst_len = 0, stay in IDLE (empty burst, no beats, no out_last).
  - RUN: accept when in_valid & in_ready. Each accept: output register <= scrambled word, out_last <= (count == 1), count <= count - 1, LFSR advances W steps. Accept with count == 1 -> IDLE.
  - reload in RUN: aborts the burst, reloads as in IDLE; no out_last for the aborted burst.
- in_ready = (state == RUN) & ~reload & (~out_valid | out_ready). reload high blocks acceptance in the same cycle (reload wins).
- Output register: single stage; holds word and out_last stable while out_valid & ~out_ready. A pending output word survives reload and is delivered normally.
- rand_iv = 0: keystream all zeros, out_bits = in_bits.
- Reset: state IDLE, s = 0, count = 0, mode = 0, out_valid = 0, out_bits = 0, out_last = 0, in_ready = 0, busy = 0. Reset mid-burst discards the pending output word.

## Timing
- Latency: accepted beat appears on out_bits the next cycle.
- Throughput: one beat per cycle while out_ready = 1; no bubbles.
- reload registered at edge N; in_ready may first be 1 in cycle N+1.
- out_valid falls the cycle after the final handshake if no new word is accepted.
- out_last is high only while the final beat is on the output.
- busy drops the cycle after the final beat is accepted, not after it drains.
- All outputs are registered except in_ready, which is combinational from state, reload, out_valid and out_ready.

## Test plan
- W=8, IV=15'h0001, burst_len=2, input 0x00,0x00, out_ready=1 -> out 0x00 then 0x60 with out_last, back-to-back; busy low after the 2nd accept.
- W=1, IV=15'h0001, 16 zero bits -> 13 zeros, 1, 1, 0; final LFSR state 15'h0006.
- bypass=1, any IV, 4 beats of 0xA5 -> out 0xA5 x4; a following burst with bypass=0 and the same IV matches a fresh scrambled run.
- out_ready held 0 for 3 cycles mid-burst -> in_ready low, out_bits/out_last stable, no beat lost or duplicated; sequence identical to the no-stall run.
- reload asserted during beat 3 of 5 with in_valid high -> beat not accepted, no out_last, new burst restarts from the new IV; burst_len=0 reload -> stays IDLE, in_ready stays 0.
- reset asserted asynchronously mid-burst with out_valid=1 -> all outputs 0 immediately; the next reload yields the same output as a fresh run.

Source files
------------

// File: rtl/randomizer_par.sv
// Word-wide 802.16 OFDM randomizer: scrambles W bits per beat with the PRBS 1 + x^14 + x^15.
// Bursts are seeded on reload, counted down in beats, and can run in bypass mode.
module randomizer_par #(
   parameter int W     = 8,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [14:0]      rand_iv,
   input  logic             reload,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             bypass,
   input  logic [W-1:0]     in_bits,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_bits,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [14:0]      lfsr, lfsr_nxt;
   logic [LEN_W-1:0] count;
   logic             mode;
   logic [W-1:0]     key;
   logic [W-1:0]     scr_bits;
   logic             accept;
   logic             last_beat;

   // Handshake: a word moves when valid and ready are both high at the rising edge.
   // Input side is held off while reload is high or the output register cannot drain.
   assign in_ready  = (state == RUN) & ~reload & (~out_valid | out_ready);
   assign accept    = in_valid & in_ready;
   assign last_beat = (count == LEN_W'(1));
   assign busy      = (state == RUN);

   // W LFSR steps unrolled, bit 0 first; the register advances in bypass as well.
   always_comb begin
      lfsr_nxt = lfsr;
      key      = '0;
      for (int i = 0; i < W; i++) begin
         key[i]   = lfsr_nxt[13] ^ lfsr_nxt[14];
         lfsr_nxt = {lfsr_nxt[13:0], key[i]};
      end
      scr_bits = mode ? in_bits : (in_bits ^ key);
   end

   always_comb begin
      state_nxt = state;
      if (reload)
         state_nxt = (burst_len != '0) ? RUN : IDLE;
      else if (accept && last_beat)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         lfsr  <= '0;
         count <= '0;
         mode  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (reload) begin
            lfsr  <= rand_iv;
            count <= burst_len;
            mode  <= bypass;
         end else if (accept) begin
            lfsr  <= lfsr_nxt;
            count <= count - LEN_W'(1);
         end
      end
   end

   // Output stage is independent of reload so a pending word still drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_bits  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_bits  <= scr_bits;
         out_valid <= 1'b1;
         out_last  <= last_beat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_randomizer_par.sv
// Bench for randomizer_par: directed and random bursts against a PRBS recurrence model,
// plus a W=1 instance for the bit-serial reference sequence.
module tb_randomizer_par;

   localparam int W = 8;
   localparam int LEN_W = 16;

   logic             clk;
   logic             reset;
   logic [14:0]      rand_iv;
   logic             reload;
   logic [LEN_W-1:0] burst_len;
   logic             bypass;
   logic [W-1:0]     in_bits;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     out_bits;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             busy;

   logic [14:0]      u_rand_iv;
   logic             u_reload;
   logic [LEN_W-1:0] u_burst_len;
   logic             u_bypass;
   logic [0:0]       u_in_bits;
   logic             u_in_valid;
   logic             u_in_ready;
   logic [0:0]       u_out_bits;
   logic             u_out_valid;
   logic             u_out_ready;
   logic             u_out_last;
   logic             u_busy;

   randomizer_par #(.W(W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .rand_iv(rand_iv), .reload(reload), .burst_len(burst_len),
      .bypass(bypass), .in_bits(in_bits), .in_valid(in_valid), .in_ready(in_ready),
      .out_bits(out_bits), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );

   randomizer_par #(.W(1), .LEN_W(LEN_W)) dut1 (
      .clk(clk), .reset(reset), .rand_iv(u_rand_iv), .reload(u_reload), .burst_len(u_burst_len),
      .bypass(u_bypass), .in_bits(u_in_bits), .in_valid(u_in_valid), .in_ready(u_in_ready),
      .out_bits(u_out_bits), .out_valid(u_out_valid), .out_ready(u_out_ready),
      .out_last(u_out_last), .busy(u_busy)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // scoreboard: {last, word} of each accepted beat, oldest first
   logic [W:0] exp_q[$];

   // model: keystream as the sequence h[n] = h[n-14] ^ h[n-15], seeded from the IV
   bit h[$];
   int kpos;
   int m_cnt;
   bit m_byp;
   bit m_run;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reload(input logic [14:0] iv, input int len, input bit byp);
      h.delete();
      for (int j = 0; j < 15; j++) h.push_back(iv[14-j]);
      kpos  = 0;
      m_cnt = len;
      m_byp = byp;
      m_run = (len != 0);
   endtask

   task automatic m_key(output logic [W-1:0] k);
      int n;
      for (int b = 0; b < W; b++) begin
         while (h.size() <= 15 + kpos) begin
            n = h.size();
            h.push_back(h[n-14] ^ h[n-15]);
         end
         k[b] = h[15 + kpos];
         kpos++;
      end
   endtask

   // one clock: inputs were set at edge+1; compare, update model, advance to next edge+1
   task automatic cycle();
      logic [W-1:0] k;
      logic         exp_rdy;
      #1;
      exp_rdy = m_run && !reload && (exp_q.size() == 0 || out_ready);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_rdy);
      chk("busy", busy, m_run);
      if (exp_q.size() != 0) begin
         chk("out_bits", out_bits, exp_q[0][W-1:0]);
         chk("out_last", out_last, exp_q[0][W]);
         if (out_ready) void'(exp_q.pop_front());
      end else begin
         chk("out_last_idle", out_last, 1'b0);
      end
      if (exp_rdy && in_valid) begin
         m_key(k);
         exp_q.push_back({m_cnt == 1, in_bits ^ (m_byp ? '0 : k)});
         m_cnt--;
         if (m_cnt == 0) m_run = 0;
      end
      if (reload) m_reload(rand_iv, int'(burst_len), bypass);
      @(posedge clk);
      #1;
   endtask

   // driver: one burst; rnd=0 streams 0xA5 with both sides always ready
   task automatic run_burst(input logic [14:0] iv, input int len, input bit byp, input bit rnd);
      int n;
      reload    = 1'b1;
      rand_iv   = iv;
      burst_len = LEN_W'(len);
      bypass    = byp;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle();
      reload = 1'b0;
      n = 0;
      while ((m_run || exp_q.size() != 0) && n < 300) begin
         in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_bits   = rnd ? W'($urandom) : W'('hA5);
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         cycle();
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("burst_timeout", n < 300, 1'b1);
   endtask

   initial begin
      logic [14:0] iv_a;
      logic [15:0] got;
      logic        u_last;
      int          n;
      int          idx;

      reset = 1'b1; rand_iv = '0; reload = 1'b0; burst_len = '0; bypass = 1'b0;
      in_bits = '0; in_valid = 1'b0; out_ready = 1'b1;
      u_rand_iv = '0; u_reload = 1'b0; u_burst_len = '0; u_bypass = 1'b0;
      u_in_bits = '0; u_in_valid = 1'b0; u_out_ready = 1'b1;
      exp_q.delete(); m_run = 0; m_cnt = 0; m_byp = 0; kpos = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_bits", out_bits, '0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // reference burst: IV=1, two zero words -> 0x00 then 0x60 with last
      reload = 1'b1; rand_iv = 15'h0001; burst_len = 2; bypass = 1'b0; out_ready = 1'b1;
      cycle();
      reload = 1'b0; in_valid = 1'b1; in_bits = '0;
      cycle();
      chk("ref_word0", {out_valid, out_last, out_bits}, {1'b1, 1'b0, 8'h00});
      cycle();
      in_valid = 1'b0;
      chk("ref_word1", {out_valid, out_last, out_bits}, {1'b1, 1'b1, 8'h60});
      chk("ref_busy_low", busy, 1'b0);
      repeat (2) cycle();

      // random bursts
      repeat (6) run_burst(15'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b1);

      // bypass then scrambled with the same IV
      iv_a = 15'($urandom_range(1, 32767));
      run_burst(iv_a, 4, 1'b1, 1'b0);
      run_burst(iv_a, 4, 1'b0, 1'b0);

      // IV zero passes data through
      run_burst(15'h0000, 3, 1'b0, 1'b1);

      // output stall for three cycles mid-burst
      reload = 1'b1; rand_iv = 15'($urandom); burst_len = 5; bypass = 1'b0; out_ready = 1'b1;
      cycle();
      reload = 1'b0;
      for (int i = 0; i < 12; i++) begin
         in_valid  = 1'b1;
         in_bits   = W'($urandom);
         out_ready = !(i >= 2 && i <= 4);
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) cycle();
      chk("stall_drained", exp_q.size() == 0 && !m_run, 1'b1);

      // reload during beat 3 of 5 aborts the burst
      reload = 1'b1; rand_iv = 15'($urandom); burst_len = 5; bypass = 1'b0;
      cycle();
      reload = 1'b0;
      n = 0;
      while (m_cnt != 3 && n < 20) begin
         in_valid = 1'b1; in_bits = W'($urandom);
         cycle();
         n++;
      end
      chk("abort_reach", n < 20, 1'b1);
      reload = 1'b1; rand_iv = 15'($urandom); burst_len = 3; in_valid = 1'b1;
      cycle();
      reload = 1'b0;
      n = 0;
      while ((m_run || exp_q.size() != 0) && n < 20) begin
         in_bits = W'($urandom);
         cycle();
         n++;
      end
      in_valid = 1'b0;
      chk("abort_done", n < 20, 1'b1);

      // empty burst stays idle
      reload = 1'b1; burst_len = 0;
      cycle();
      reload = 1'b0; in_valid = 1'b1;
      repeat (3) cycle();
      chk("empty_ready", in_ready, 1'b0);
      chk("empty_busy", busy, 1'b0);
      in_valid = 1'b0;

      // asynchronous reset with a pending output word
      iv_a = 15'($urandom);
      reload = 1'b1; rand_iv = iv_a; burst_len = 4; bypass = 1'b0; out_ready = 1'b0;
      cycle();
      reload = 1'b0; in_valid = 1'b1; in_bits = W'($urandom);
      cycle();
      chk("pre_rst_valid", out_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_bits", out_bits, '0);
      chk("arst_out_last", out_last, 1'b0);
      chk("arst_in_ready", in_ready, 1'b0);
      chk("arst_busy", busy, 1'b0);
      exp_q.delete(); m_run = 0; m_cnt = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      run_burst(iv_a, 4, 1'b0, 1'b1);

      // W=1 instance: 16 zero bits from IV=1
      u_rand_iv = 15'h0001; u_burst_len = 16; u_reload = 1'b1;
      @(posedge clk);
      #1;
      u_reload = 1'b0; u_in_valid = 1'b1; u_in_bits = 1'b0; u_out_ready = 1'b1;
      got = '0; u_last = 1'b0; idx = 0; n = 0;
      while (idx < 16 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (u_out_valid) begin
            got[idx] = u_out_bits[0];
            u_last   = u_out_last;
            idx++;
         end
      end
      u_in_valid = 1'b0;
      chk("w1_count", idx, 16);
      chk("w1_stream", got, 16'h6000);
      chk("w1_last", u_last, 1'b1);
      chk("w1_lfsr", dut1.lfsr, 15'h0006);
      chk("w1_busy", u_busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
